xbar_port_arbiter: RTL and testbench

Per-output-port arbiter and packet sequencer for the 8x8 crossbar; one instance sits on each output.
- Watches all input lanes for valid headers addressed to its port and grants one lane round-robin.
- Streams header plus fixed-length payload from the granted lane to the output with a valid/ready handshake.
- Checks header and payload parity, and drops packets with a corrupt header.

---
 rtl/xbar_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_xbar_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_port_arbiter.sv
// Output-port arbiter: round-robin lane grant, header+payload pass-through, parity checks, bad-header drop.
// Lane-to-output is combinational once granted; one IDLE bubble per packet; in_ready follows out_ready, so a stalled output stalls the lane.
module xbar_port_arbiter #(
  parameter int PORTS         = 8,
  parameter int PORT_ID       = 0,
  parameter int PKT_W         = 8,
  parameter int PAYLOAD_BEATS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS*PKT_W-1:0]     in_data,
  input  logic [PORTS-1:0]           in_valid,
  output logic [PORTS-1:0]           in_ready,
  output logic [PKT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PORTS-1:0]           grant,
  output logic                       busy,
  output logic                       hdr_err,
  output logic                       pay_err,
  output logic [$clog2(PORTS)-1:0]   err_port
);

  localparam int AW = $clog2(PORTS);
  localparam int CW = $clog2(PAYLOAD_BEATS + 1);

  typedef enum logic [1:0] {IDLE, HDR, PAY, DROP} state_t;

  state_t            state, state_nxt;
  logic [PORTS-1:0]  grant_nxt;
  logic [AW-1:0]     g_idx, g_nxt;
  logic [AW-1:0]     ptr, ptr_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              ppar, ppar_nxt;
  logic              acc, acc_nxt;
  logic              hdr_err_nxt, pay_err_nxt;
  logic [AW-1:0]     err_port_nxt;

  logic [PKT_W-1:0]  lane [PORTS];
  logic [PORTS-1:0]  req;
  logic              pick_vld;
  logic [AW-1:0]     pick_idx;
  logic [PKT_W-1:0]  g_dat;
  logic              g_vld;
  logic              hs;
  logic              pay_par;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      lane[i] = in_data[PKT_W*i +: PKT_W];
      req[i]  = in_valid[i] && lane[i][7] && (lane[i][6:4] == 3'(PORT_ID));
    end
  end

  // First requester after the pointer, wrapping; the pointer lane itself is checked last.
  always_comb begin
    logic [AW-1:0] idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = '0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = AW'((int'(ptr) + k) % PORTS);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      g_idx    <= '0;
      ptr      <= AW'(PORTS - 1);
      cnt      <= '0;
      ppar     <= 1'b0;
      acc      <= 1'b0;
      hdr_err  <= 1'b0;
      pay_err  <= 1'b0;
      err_port <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      g_idx    <= g_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      ppar     <= ppar_nxt;
      acc      <= acc_nxt;
      hdr_err  <= hdr_err_nxt;
      pay_err  <= pay_err_nxt;
      err_port <= err_port_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    g_nxt        = g_idx;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    ppar_nxt     = ppar;
    acc_nxt      = acc;
    hdr_err_nxt  = 1'b0;
    pay_err_nxt  = 1'b0;
    err_port_nxt = err_port;
    out_data     = '0;
    out_valid    = 1'b0;
    in_ready     = '0;
    g_dat        = lane[g_idx];
    g_vld        = in_valid[g_idx];
    hs           = g_vld && out_ready;
    pay_par      = acc ^ (^g_dat);

    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = {{(PORTS-1){1'b0}}, 1'b1} << pick_idx;
          g_nxt     = pick_idx;
          cnt_nxt   = '0;
          if ((^lane[pick_idx][7:1]) == lane[pick_idx][0]) begin
            state_nxt = HDR;
          end else begin
            state_nxt    = DROP;
            hdr_err_nxt  = 1'b1;
            err_port_nxt = pick_idx;
          end
        end
      end
      HDR: begin
        out_data        = g_dat;
        out_valid       = g_vld;
        in_ready[g_idx] = out_ready;
        if (hs) begin
          state_nxt = PAY;
          cnt_nxt   = '0;
          ppar_nxt  = g_dat[1];
          acc_nxt   = 1'b0;
        end
      end
      PAY: begin
        out_data        = g_dat;
        out_valid       = g_vld;
        in_ready[g_idx] = out_ready;
        if (hs) begin
          cnt_nxt = cnt + CW'(1);
          acc_nxt = pay_par;
          if (cnt == CW'(PAYLOAD_BEATS - 1)) begin
            state_nxt = IDLE;
            ptr_nxt   = g_idx;
            grant_nxt = '0;
            if (pay_par != ppar) begin
              pay_err_nxt  = 1'b1;
              err_port_nxt = g_idx;
            end
          end
        end
      end
      DROP: begin
        // Swallow header plus payload without presenting anything downstream.
        in_ready[g_idx] = g_vld;
        if (g_vld) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(PAYLOAD_BEATS)) begin
            state_nxt = IDLE;
            ptr_nxt   = g_idx;
            grant_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_xbar_port_arbiter.sv
// Bench for xbar_port_arbiter: directed packet scenarios plus randomized traffic against a packet-level model.
module tb_xbar_port_arbiter;

  localparam int PORTS   = 8;
  localparam int PORT_ID = 3;
  localparam int PKT_W   = 8;
  localparam int PB      = 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [PORTS*PKT_W-1:0]   in_data = '0;
  logic [PORTS-1:0]         in_valid = '0;
  logic [PORTS-1:0]         in_ready;
  logic [PKT_W-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [PORTS-1:0]         grant;
  logic                     busy;
  logic                     hdr_err;
  logic                     pay_err;
  logic [2:0]               err_port;

  always #5 clk = ~clk;

  xbar_port_arbiter #(
    .PORTS(PORTS), .PORT_ID(PORT_ID), .PKT_W(PKT_W), .PAYLOAD_BEATS(PB)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .grant(grant),
    .busy(busy), .hdr_err(hdr_err), .pay_err(pay_err), .err_port(err_port)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]       lq [PORTS][$];
  bit               rnd_mode = 1'b0;
  bit               chk_on = 1'b0;
  logic [PORTS-1:0] acc_mask = '0;

  // Packet-level model: who owns the port, whether the packet is being discarded, bytes taken so far.
  bit         m_busy = 1'b0;
  bit         m_drop = 1'b0;
  int         m_own = 0;
  int         m_ptr = PORTS - 1;
  logic [7:0] m_pkt [$];
  bit         e_hdr = 1'b0;
  bit         e_pay = 1'b0;
  int         e_port = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_byte(input int l);
    return in_data[PKT_W*l +: PKT_W];
  endfunction

  task automatic model_step();
    logic [7:0] h;
    bit         p;
    int         l;
    if (rst) begin
      m_busy = 0; m_drop = 0; m_own = 0; m_ptr = PORTS - 1;
      e_hdr = 0; e_pay = 0; e_port = 0;
      m_pkt.delete();
      return;
    end
    e_hdr = 0;
    e_pay = 0;
    if (!m_busy) begin
      for (int k = 1; k <= PORTS; k++) begin
        l = (m_ptr + k) % PORTS;
        h = lane_byte(l);
        if (in_valid[l] && h[7] && (int'(h[6:4]) == PORT_ID)) begin
          m_busy = 1;
          m_own  = l;
          m_pkt.delete();
          m_drop = ^h;  // a good header has even parity over all eight bits
          if (m_drop) begin
            e_hdr  = 1;
            e_port = l;
          end
          break;
        end
      end
    end else if (in_valid[m_own] && (m_drop || out_ready)) begin
      m_pkt.push_back(lane_byte(m_own));
      if (m_pkt.size() == PB + 1) begin
        if (!m_drop) begin
          p = 0;
          for (int j = 1; j <= PB; j++) p = p ^ (^m_pkt[j]);
          h = m_pkt[0];
          if (p != h[1]) begin
            e_pay  = 1;
            e_port = m_own;
          end
        end
        m_busy = 0;
        m_ptr  = m_own;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [PORTS-1:0] x_rdy;
    logic [PORTS-1:0] x_gnt;
    logic             x_vld;
    acc_mask = in_valid & in_ready;
    if (chk_on) begin
      x_gnt = m_busy ? (PORTS'(1) << m_own) : '0;
      x_vld = m_busy && !m_drop && in_valid[m_own];
      x_rdy = '0;
      if (m_busy) x_rdy[m_own] = m_drop ? in_valid[m_own] : out_ready;
      chk("m_grant", grant, x_gnt);
      chk("m_busy", busy, m_busy);
      chk("m_out_valid", out_valid, x_vld);
      if (x_vld) chk("m_out_data", out_data, lane_byte(m_own));
      chk("m_in_ready", in_ready, x_rdy);
      chk("m_hdr_err", hdr_err, e_hdr);
      chk("m_pay_err", pay_err, e_pay);
      chk("m_err_port", err_port, e_port);
    end
    model_step();
  end

  task automatic drive();
    bit v;
    for (int i = 0; i < PORTS; i++) begin
      v = (lq[i].size() > 0) && (!rnd_mode || $urandom_range(3) != 0);
      in_valid[i] = v;
      in_data[PKT_W*i +: PKT_W] = v ? lq[i][0] : (rnd_mode ? 8'($urandom) : 8'h00);
    end
    if (rnd_mode) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic refill();
    logic [7:0] h;
    for (int i = 0; i < PORTS; i++) begin
      if (lq[i].size() == 0 && $urandom_range(1) == 1) begin
        h = {1'b1, 3'(PORT_ID), 2'($urandom_range(3)), 1'($urandom_range(1)), 1'b0};
        h[0] = ^h[7:1];
        if ($urandom_range(7) == 0) h[0] = ~h[0];
        lq[i].push_back(h);
        for (int j = 0; j < PB; j++) lq[i].push_back(8'($urandom));
      end
    end
  endtask

  task automatic flush();
    for (int i = 0; i < PORTS; i++) lq[i].delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < PORTS; i++)
      if (acc_mask[i] && lq[i].size() > 0) void'(lq[i].pop_front());
    if (rnd_mode) refill();
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    drive();
    tick();
    rst = 1'b0;
    drive();
  endtask

  task automatic load(input int l, input logic [7:0] a, input logic [7:0] b);
    lq[l].push_back(a);
    lq[l].push_back(b);
  endtask

  initial begin
    int n;
    drive();
    do_reset();
    chk_on = 1'b1;

    // Reset state with no requests present
    @(negedge clk);
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0); chk("rst_in_ready", in_ready, 0);
    chk("rst_hdr_err", hdr_err, 0); chk("rst_pay_err", pay_err, 0); chk("rst_err_port", err_port, 0);

    // Single good packet on lane 2
    tick();
    load(2, 8'hB4, 8'h0F); drive();
    @(negedge clk); chk("t1_c0_grant", grant, 8'h00); chk("t1_c0_in_ready", in_ready, 8'h00);
    tick(); @(negedge clk);
    chk("t1_c1_grant", grant, 8'h04); chk("t1_c1_data", out_data, 8'hB4);
    chk("t1_c1_valid", out_valid, 1); chk("t1_c1_in_ready", in_ready, 8'h04);
    tick(); @(negedge clk);
    chk("t1_c2_data", out_data, 8'h0F); chk("t1_c2_in_ready", in_ready, 8'h04);
    tick(); @(negedge clk);
    chk("t1_c3_busy", busy, 0); chk("t1_c3_grant", grant, 0);
    chk("t1_c3_pay_err", pay_err, 0); chk("t1_c3_hdr_err", hdr_err, 0);

    // All lanes contending: round-robin 0..7,0 with an idle cycle between packets
    tick(); do_reset();
    for (int i = 0; i < PORTS; i++) begin load(i, 8'hB4, 8'h0F); load(i, 8'hB4, 8'h0F); end
    drive();
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      if (c % 3 == 1) chk("t2_grant", grant, 8'(1) << (((c - 1) / 3) % PORTS));
      if (c % 3 == 0) chk("t2_bubble", grant, 0);
      tick();
    end

    // Bad header parity on lane 5, then a good packet on the same lane
    do_reset();
    load(5, 8'hB5, 8'h0F); load(5, 8'hB4, 8'h0F); drive();
    tick(); @(negedge clk);
    chk("t3_c1_hdr_err", hdr_err, 1); chk("t3_c1_err_port", err_port, 5);
    chk("t3_c1_in_ready", in_ready, 8'h20); chk("t3_c1_valid", out_valid, 0);
    tick(); @(negedge clk);
    chk("t3_c2_hdr_err", hdr_err, 0); chk("t3_c2_in_ready", in_ready, 8'h20); chk("t3_c2_valid", out_valid, 0);
    tick(); @(negedge clk);
    chk("t3_c3_busy", busy, 0); chk("t3_c3_valid", out_valid, 0);
    tick(); @(negedge clk);
    chk("t3_c4_grant", grant, 8'h20); chk("t3_c4_data", out_data, 8'hB4); chk("t3_c4_valid", out_valid, 1);

    // Payload parity mismatch on lane 1
    tick(); do_reset();
    load(1, 8'hB4, 8'h07); drive();
    tick(); @(negedge clk); chk("t4_c1_data", out_data, 8'hB4);
    tick(); @(negedge clk); chk("t4_c2_data", out_data, 8'h07); chk("t4_c2_pay_err", pay_err, 0);
    tick(); @(negedge clk); chk("t4_c3_pay_err", pay_err, 1); chk("t4_c3_err_port", err_port, 1);
    tick(); @(negedge clk); chk("t4_c4_pay_err", pay_err, 0);

    // Output backpressure during the payload beat
    tick(); do_reset();
    load(0, 8'hB4, 8'h0F); drive();
    n = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      @(negedge clk);
      if (out_valid && out_ready) n++;
      if (c >= 2 && c <= 4) begin
        chk("t5_hold_valid", out_valid, 1); chk("t5_hold_data", out_data, 8'h0F);
        chk("t5_hold_in_ready", in_ready, 0);
      end
      if (c == 5) chk("t5_release_in_ready", in_ready, 8'h01);
      tick();
    end
    out_ready = 1'b1;
    chk("t5_delivered", n, 2);

    // Headers for another port or with the valid bit clear are ignored
    do_reset();
    load(4, 8'hC4, 8'h0F); load(6, 8'h34, 8'h0F); drive();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("t6_in_ready", in_ready, 0); chk("t6_grant", grant, 0);
      tick();
    end

    // Reset mid-payload; lane 0 wins afterwards even though lane 1 was served last
    do_reset();
    load(1, 8'hB4, 8'h0F); load(1, 8'hB4, 8'h0F); drive();
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk); chk("t6_pre_rst_grant", grant, 8'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0; flush(); load(0, 8'hB4, 8'h0F); load(2, 8'hB4, 8'h0F); drive();
    @(negedge clk);
    chk("t6_rst_grant", grant, 0); chk("t6_rst_busy", busy, 0); chk("t6_rst_valid", out_valid, 0);
    tick(); @(negedge clk); chk("t6_after_rst_grant", grant, 8'h01);

    // Randomized traffic with occasional resets
    tick(); do_reset();
    rnd_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = 1'b0;
      if ($urandom_range(399) == 0) begin
        rst = 1'b1;
        flush();
        drive();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
